parking_space_counter: RTL

Sequential occupancy tracker for the parking system. It debounces the entry and exit car sensors and keeps a saturating count of occupied spaces. It drives the free-space count as a 4-bit BCD digit on A/B/C/D, the input side of the seven-segment decoder. It also issues per-car grant/reject pulses for the gate controller.

---
 rtl/parking_pkg.sv | 18 +
 rtl/sensor_debounce.sv | 60 ++++++
 rtl/parking_space_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy tracker.
package parking_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_W-1:0] occ_t;

   // Free spaces as a single BCD digit, clamped so it can never exceed 9
   // or go negative even if occupancy were somehow out of range.
   function automatic occ_t free_bcd(input occ_t cap, input occ_t occ);
      occ_t f;
      f = (occ >= cap) ? '0 : occ_t'(cap - occ);
      if (f > BCD_MAX) f = BCD_MAX;
      return f;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor lane: 2-flop synchronizer, counter debounce, registered rise pulse.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic             r_rise;
   logic [CNT_W-1:0] r_cnt;

   // Bring the asynchronous sensor into the clock domain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_stable <= ~r_stable;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Register a one-cycle pulse on each 0->1 transition of the debounced level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stable_d <= 1'b0;
         r_rise     <= 1'b0;
      end else begin
         r_stable_d <= r_stable;
         r_rise     <= r_stable & ~r_stable_d;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/parking_space_counter.sv
// Occupancy counter with entry/exit arbitration and registered BCD/flag outputs.
module parking_space_counter
   import parking_pkg::*;
#(
   parameter int CAPACITY        = 9,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic entry_sensor,
   input  logic exit_sensor,
   output logic A,
   output logic B,
   output logic C,
   output logic D,
   output logic full,
   output logic empty,
   output logic entry_grant,
   output logic entry_reject
);

   localparam occ_t CAP = occ_t'(CAPACITY);

   generate
      if (CAPACITY < 1 || CAPACITY > 9) begin : g_bad_capacity
         $error("parking_space_counter: CAPACITY must be in 1..9");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
         $error("parking_space_counter: DEBOUNCE_CYCLES must be >= 1");
      end
   endgenerate

   logic w_en;
   logic w_ex;
   occ_t w_occ_next;
   logic w_grant;
   logic w_reject;

   occ_t r_occ;
   occ_t r_bcd;
   logic r_full;
   logic r_empty;
   logic r_grant;
   logic r_reject;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (entry_sensor),
      .o_rise (w_en)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (exit_sensor),
      .o_rise (w_ex)
   );

   // Resolve entry/exit events; a simultaneous exit frees the space for the entering car.
   always_comb begin
      w_occ_next = r_occ;
      w_grant    = 1'b0;
      w_reject   = 1'b0;
      case ({w_en, w_ex})
         2'b10: begin
            if (r_occ < CAP) begin
               w_occ_next = r_occ + 4'd1;
               w_grant    = 1'b1;
            end else begin
               w_reject = 1'b1;
            end
         end
         2'b01: begin
            if (r_occ != '0) w_occ_next = r_occ - 4'd1;
         end
         2'b11: begin
            w_grant = 1'b1;
            // An exit with nobody inside is spurious; the entry still counts.
            if (r_occ == '0) w_occ_next = 4'd1;
         end
         default: ;
      endcase
   end

   // Update occupancy and derive all outputs from the new value on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_occ    <= '0;
         r_bcd    <= free_bcd(CAP, '0);
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_grant  <= 1'b0;
         r_reject <= 1'b0;
      end else begin
         r_occ    <= w_occ_next;
         r_bcd    <= free_bcd(CAP, w_occ_next);
         r_full   <= (w_occ_next == CAP);
         r_empty  <= (w_occ_next == '0);
         r_grant  <= w_grant;
         r_reject <= w_reject;
      end
   end

   assign A            = r_bcd[3];
   assign B            = r_bcd[2];
   assign C            = r_bcd[1];
   assign D            = r_bcd[0];
   assign full         = r_full;
   assign empty        = r_empty;
   assign entry_grant  = r_grant;
   assign entry_reject = r_reject;

endmodule
